read_empty_ctrl_ext: RTL and testbench

Read-side pointer and flag controller for the async FIFO, successor to the basic read/empty handler. It keeps the binary and Gray read pointers, derives empty, almost-empty and fill level from the synchronized write pointer, and flags underflow. A parameter selects standard mode or first-word-fall-through (FWFT) mode with an output holding register. The block sits in the rclk domain between the 2-flop write-pointer synchronizer and the dual-port memory read port.

---
 rtl/read_empty_ctrl_ext_if.sv | 43 ++++
 rtl/read_empty_ctrl_ext.sv | 110 +++++++++++
 tb/tb_read_empty_ctrl_ext.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/read_empty_ctrl_ext_if.sv
// ---------------------------------------------------------------------------
// read_empty_ctrl_ext_if
// Purpose : groups the read-side FIFO controller signals (reader handshake,
//           synchronized write pointer, memory read port and status flags).
// Modports:
//   slave  - the controller: takes rinc/rclr_err/rq2_wptr/rmem_rdata,
//            drives raddr/rmem_en/rptr/flags/level/rdata/rvalid/runderflow
//   master - the surroundings (reader, synchronizer, memory)
// Handshake: standard mode - a word is taken on a clock edge where
//            rinc=1 and rempty=0. FWFT mode - rdata is valid while rvalid=1
//            and is consumed on an edge where rinc=1 and rvalid=1. rinc in
//            any other cycle is an underflow and leaves the pointers alone.
// ---------------------------------------------------------------------------
interface read_empty_ctrl_ext_if #(
    parameter int ps = 4,
    parameter int dw = 8
);
    logic          rinc;
    logic          rclr_err;
    logic [ps:0]   rq2_wptr;
    logic [dw-1:0] rmem_rdata;
    logic [ps-1:0] raddr;
    logic          rmem_en;
    logic [ps:0]   rptr;
    logic          rempty;
    logic          ralmost_empty;
    logic [ps:0]   rlevel;
    logic [dw-1:0] rdata;
    logic          rvalid;
    logic          runderflow;

    modport slave (
        input  rinc, rclr_err, rq2_wptr, rmem_rdata,
        output raddr, rmem_en, rptr, rempty, ralmost_empty, rlevel,
               rdata, rvalid, runderflow
    );

    modport master (
        output rinc, rclr_err, rq2_wptr, rmem_rdata,
        input  raddr, rmem_en, rptr, rempty, ralmost_empty, rlevel,
               rdata, rvalid, runderflow
    );
endinterface

// File: rtl/read_empty_ctrl_ext.sv
// ---------------------------------------------------------------------------
// read_empty_ctrl_ext
// Purpose : read-side pointer and flag controller of an async FIFO (rclk
//           domain). Keeps binary/Gray read pointers, derives empty,
//           almost-empty and fill level from the synchronized Gray write
//           pointer, flags sticky underflow. fwft=1 adds an output holding
//           register so the head word is presented without a request.
// Ports   :
//   rclk, rrst - read clock, asynchronous active-high reset
//   bus        - read_empty_ctrl_ext_if.slave (see interface header)
// ---------------------------------------------------------------------------
module read_empty_ctrl_ext #(
    parameter int ps        = 4,
    parameter int dw        = 8,
    parameter int ae_thresh = 2,
    parameter int fwft      = 0
) (
    input  logic                  rclk,
    input  logic                  rrst,
    read_empty_ctrl_ext_if.slave  bus
);
    logic [ps:0]   r_bptr;
    logic [ps:0]   r_rptr;
    logic [ps:0]   r_level;
    logic          r_memempty;
    logic          r_ae;
    logic          r_rvalid;
    logic          r_underflow;
    logic [dw-1:0] r_hold;

    logic          w_pop;
    logic          w_uf;
    logic [ps:0]   w_wbin;
    logic [ps:0]   w_bnext;
    logic [ps:0]   w_gnext;
    logic [ps:0]   w_level_next;

    // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        w_wbin = '0;
        for (int i = 0; i <= ps; i++) begin
            w_wbin[i] = ^(bus.rq2_wptr >> i);
        end
    end

    // Pop and underflow qualification. In FWFT mode the memory is read to
    // refill the holding register whenever it is empty or being consumed.
    always_comb begin
        w_pop = 1'b0;
        w_uf  = 1'b0;
        if (fwft != 0) begin
            w_pop = ~r_memempty & (~r_rvalid | bus.rinc);
            w_uf  = bus.rinc & ~r_rvalid;
        end else begin
            w_pop = bus.rinc & ~r_memempty;
            w_uf  = bus.rinc & r_memempty;
        end
    end

    assign w_bnext      = r_bptr + (ps+1)'(w_pop);
    assign w_gnext      = (w_bnext >> 1) ^ w_bnext;
    // Flags use the post-pop pointer so a word popped this cycle never
    // shows up as still available after the edge.
    assign w_level_next = w_wbin - w_bnext;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_bptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_memempty  <= 1'b1;
            r_ae        <= 1'b1;
            r_rvalid    <= 1'b0;
            r_hold      <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_bptr     <= w_bnext;
            r_rptr     <= w_gnext;
            r_memempty <= (w_gnext == bus.rq2_wptr);
            r_level    <= w_level_next;
            r_ae       <= (32'(w_level_next) <= 32'(ae_thresh));

            if (fwft != 0) begin
                if (w_pop) begin
                    r_hold   <= bus.rmem_rdata;
                    r_rvalid <= 1'b1;
                end else if (bus.rinc & r_rvalid) begin
                    r_rvalid <= 1'b0;
                end
            end

            // A new underflow beats a simultaneous clear.
            if (w_uf) begin
                r_underflow <= 1'b1;
            end else if (bus.rclr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.raddr         = r_bptr[ps-1:0];
    assign bus.rmem_en       = w_pop;
    assign bus.rptr          = r_rptr;
    assign bus.ralmost_empty = r_ae;
    assign bus.rlevel        = r_level;
    assign bus.runderflow    = r_underflow;
    assign bus.rempty        = (fwft != 0) ? ~r_rvalid : r_memempty;
    assign bus.rdata         = (fwft != 0) ? r_hold : bus.rmem_rdata;
    assign bus.rvalid        = (fwft != 0) ? r_rvalid : 1'b0;
endmodule

// File: tb/tb_read_empty_ctrl_ext.sv
// Bench for read_empty_ctrl_ext: one standard-mode and one FWFT instance share
// a memory model and a write-count stream. Expected values come from a
// word-count model (words written, words read, head-of-queue data).
module tb_read_empty_ctrl_ext;
    localparam int PS = 4;
    localparam int DW = 8;
    localparam int AE = 2;
    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    read_empty_ctrl_ext_if #(.ps(PS), .dw(DW)) rif_s ();
    read_empty_ctrl_ext_if #(.ps(PS), .dw(DW)) rif_f ();

    logic [DW-1:0] mem [0:DEPTH-1];
    assign rif_s.rmem_rdata = mem[rif_s.raddr];
    assign rif_f.rmem_rdata = mem[rif_f.raddr];

    read_empty_ctrl_ext #(.ps(PS), .dw(DW), .ae_thresh(AE), .fwft(0)) dut_s (
        .rclk (clk),
        .rrst (rst),
        .bus  (rif_s.slave)
    );

    read_empty_ctrl_ext #(.ps(PS), .dw(DW), .ae_thresh(AE), .fwft(1)) dut_f (
        .rclk (clk),
        .rrst (rst),
        .bus  (rif_f.slave)
    );

    // ---------------- model state / scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    int wcnt;          // words written so far
    int wvis_prev;     // write count visible to the reader at the last edge
    int rd_s, rd_f;    // words taken from memory by each instance
    bit uf_s, uf_f;
    bit hv;            // FWFT holding word present
    logic [DW-1:0] hd; // FWFT holding word
    logic [DW-1:0] exp_s[$];
    logic [DW-1:0] exp_f[$];

    function automatic logic [PS:0] gray(int c);
        logic [PS:0] b;
        b = (PS+1)'(c);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_word(logic [DW-1:0] d);
        mem[wcnt % DEPTH] = d;
        exp_s.push_back(d);
        exp_f.push_back(d);
        wcnt++;
    endtask

    task automatic drive(bit ri, bit cl);
        rif_s.rinc = ri;      rif_f.rinc = ri;
        rif_s.rclr_err = cl;  rif_f.rclr_err = cl;
        rif_s.rq2_wptr = gray(wcnt);
        rif_f.rq2_wptr = gray(wcnt);
    endtask

    task automatic check_reset();
        chk("s_rst_rempty", rif_s.rempty, 1);
        chk("s_rst_ae", rif_s.ralmost_empty, 1);
        chk("s_rst_level", rif_s.rlevel, 0);
        chk("s_rst_rptr", rif_s.rptr, 0);
        chk("s_rst_raddr", rif_s.raddr, 0);
        chk("s_rst_rvalid", rif_s.rvalid, 0);
        chk("s_rst_uf", rif_s.runderflow, 0);
        chk("s_rst_men", rif_s.rmem_en, 0);
        chk("f_rst_rempty", rif_f.rempty, 1);
        chk("f_rst_ae", rif_f.ralmost_empty, 1);
        chk("f_rst_level", rif_f.rlevel, 0);
        chk("f_rst_rptr", rif_f.rptr, 0);
        chk("f_rst_raddr", rif_f.raddr, 0);
        chk("f_rst_rvalid", rif_f.rvalid, 0);
        chk("f_rst_rdata", rif_f.rdata, 0);
        chk("f_rst_uf", rif_f.runderflow, 0);
        chk("f_rst_men", rif_f.rmem_en, 0);
    endtask

    task automatic model_reset();
        wcnt = 0; wvis_prev = 0; rd_s = 0; rd_f = 0;
        uf_s = 0; uf_f = 0; hv = 0; hd = '0;
        exp_s.delete();
        exp_f.delete();
    endtask

    task automatic check_post();
        int lvl_s, lvl_f;
        lvl_s = wcnt - rd_s;
        lvl_f = wcnt - rd_f;
        chk("s_rlevel", rif_s.rlevel, lvl_s);
        chk("s_rempty", rif_s.rempty, lvl_s == 0);
        chk("s_ae", rif_s.ralmost_empty, lvl_s <= AE);
        chk("s_rptr", rif_s.rptr, gray(rd_s));
        chk("s_raddr", rif_s.raddr, rd_s % DEPTH);
        chk("s_uf", rif_s.runderflow, uf_s);
        chk("s_rvalid", rif_s.rvalid, 0);
        chk("f_rlevel", rif_f.rlevel, lvl_f);
        chk("f_ae", rif_f.ralmost_empty, lvl_f <= AE);
        chk("f_rptr", rif_f.rptr, gray(rd_f));
        chk("f_raddr", rif_f.raddr, rd_f % DEPTH);
        chk("f_rempty", rif_f.rempty, !hv);
        chk("f_rvalid", rif_f.rvalid, hv);
        chk("f_uf", rif_f.runderflow, uf_f);
        if (hv) chk("f_rdata", rif_f.rdata, hd);
    endtask

    // One clock cycle: optional writes, drive, pre-edge checks, edge, model update.
    task automatic cycle(int wr_n, bit ri, bit cl);
        int av_s, av_f, min_rd;
        bit pop_s, pop_f, cons;
        for (int i = 0; i < wr_n; i++) begin
            min_rd = (rd_s < rd_f) ? rd_s : rd_f;
            if (wcnt - min_rd < DEPTH) write_word(DW'($urandom_range(0, 255)));
        end
        drive(ri, cl);
        #3;
        av_s  = wvis_prev - rd_s;
        pop_s = ri && (av_s > 0);
        av_f  = wvis_prev - rd_f;
        pop_f = (av_f > 0) && (!hv || ri);
        cons  = ri && hv;
        chk("s_rmem_en", rif_s.rmem_en, pop_s);
        chk("f_rmem_en", rif_f.rmem_en, pop_f);
        if (pop_s) chk("s_rdata", rif_s.rdata, exp_s[0]);
        @(posedge clk);
        #1;
        if (ri && av_s == 0) uf_s = 1;
        else if (cl) uf_s = 0;
        if (pop_s) begin
            rd_s++;
            void'(exp_s.pop_front());
        end
        if (ri && !hv) uf_f = 1;
        else if (cl) uf_f = 0;
        if (pop_f) begin
            hd = exp_f.pop_front();
            hv = 1;
            rd_f++;
        end else if (cons) begin
            hv = 0;
        end
        wvis_prev = wcnt;
        check_post();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1;
        model_reset();
        drive(0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_post();

        // Five words, then pop them all.
        cycle(5, 0, 0);
        chk("t1_level5", rif_s.rlevel, 5);
        chk("t1_nonempty", rif_s.rempty, 0);
        chk("t1_ae0", rif_s.ralmost_empty, 0);
        repeat (5) cycle(0, 1, 0);
        chk("t1_rptr", rif_s.rptr, 5'b00111);
        chk("t1_empty", rif_s.rempty, 1);

        // Wrap past bin 16 to bin 20 in two batches.
        cycle(10, 0, 0);
        repeat (10) cycle(0, 1, 0);
        cycle(5, 0, 0);
        repeat (5) cycle(0, 1, 0);
        chk("t2_rptr", rif_s.rptr, 5'b11110);
        chk("t2_empty", rif_s.rempty, 1);
        chk("t2_level", rif_s.rlevel, 0);
        chk("t2_no_uf", rif_s.runderflow, 0);

        // Underflow: set, hold, clear, set-beats-clear.
        cycle(0, 1, 0);
        chk("t3_uf_set", rif_s.runderflow, 1);
        chk("t3_rptr_hold", rif_s.rptr, 5'b11110);
        cycle(0, 0, 0);
        chk("t3_uf_hold", rif_s.runderflow, 1);
        cycle(0, 0, 1);
        chk("t3_uf_clr", rif_s.runderflow, 0);
        cycle(0, 1, 1);
        chk("t3_uf_setwins", rif_s.runderflow, 1);
        cycle(0, 0, 1);

        // Asynchronous reset between edges while words are in flight.
        cycle(4, 0, 0);
        cycle(0, 1, 0);
        #3;
        rst = 1'b1;
        model_reset();
        drive(0, 0);
        #1;
        check_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_post();
        cycle(0, 0, 0);
        cycle(0, 0, 0);

        // FWFT: single word appears two edges after the write pointer moves.
        write_word(8'hA5);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("t4_rvalid", rif_f.rvalid, 1);
        chk("t4_rdata", rif_f.rdata, 8'hA5);
        chk("t4_level", rif_f.rlevel, 0);
        chk("t4_rempty", rif_f.rempty, 0);
        cycle(0, 1, 0);

        // FWFT streaming without bubbles.
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("t5_d11", rif_f.rdata, 8'h11);
        cycle(0, 1, 0);
        chk("t5_d22", rif_f.rdata, 8'h22);
        chk("t5_v22", rif_f.rvalid, 1);
        cycle(0, 1, 0);
        chk("t5_d33", rif_f.rdata, 8'h33);
        chk("t5_v33", rif_f.rvalid, 1);
        cycle(0, 1, 0);
        chk("t5_vdrop", rif_f.rvalid, 0);
        chk("t5_no_uf", rif_f.runderflow, 0);

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            cycle($urandom_range(0, 2), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
